matrix_ascii_rx: RTL and testbench
==================================

MATRIX_ASCII_RX -- requirements
Module: matrix_ascii_rx

Interface
REQ-001 Parameter ELEM_WIDTH, default 8, element width in bits.
REQ-002 Parameter MAX_DIM, default 5, maximum rows and columns.
REQ-003 Port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1, asynchronous active-low reset.
REQ-005 Port start, input, 1, one-cycle pulse that begins a matrix read; ignored while busy.
REQ-006 Port m, input, 4, row count; sampled at start.
REQ-007 Port n, input, 4, column count; sampled at start.
REQ-008 Port rx_valid, input, 1, one-cycle strobe from the UART receiver: rx_data holds a byte.
REQ-009 Port rx_data, input, 8, received ASCII byte.
REQ-010 Port mat_out, output, 200, row-major packed matrix; element k occupies bits [k*8 +: 8].
REQ-011 Port busy, output, 1, high from the start acceptance cycle until done or error.
REQ-012 Port done, output, 1, one-cycle pulse: m*n elements stored.
REQ-013 Port error, output, 1, one-cycle pulse: read aborted.
REQ-014 Port err_code, output, 2, cause of the last error, held until the next start: 0 none, 1 bad dimension, 2 bad character, 3 value overflow.

Function
REQ-015 States: S_IDLE, S_SKIP (discard separators), S_NUM (accumulate digits), S_COMMIT, S_DONE, S_ERR.
REQ-016 S_IDLE + start: latch m and n; clear mat_out to zero, count to 0, accumulator to 0, err_code to 0; busy=1; next state S_SKIP.
REQ-017 At start, if m or n is 0 or greater than MAX_DIM: next state S_ERR with err_code=1 instead of S_SKIP.
REQ-018 Separators are 0x20, 0x0A and 0x0D; digits are 0x30-0x39; any other byte is an illegal character.
REQ-019 S_SKIP + separator: stay in S_SKIP.
REQ-020 S_SKIP + digit: accumulator = digit value; next state S_NUM.
REQ-021 S_NUM + digit: accumulator = accumulator*10 + digit, computed in a 12-bit accumulator.
REQ-022 If that result exceeds 255: next state S_ERR with err_code=3.
REQ-023 S_NUM + separator: next state S_COMMIT.
REQ-024 Leading zeros are legal ("007" = 7).
REQ-025 An illegal character in S_SKIP or S_NUM: next state S_ERR with err_code=2.
REQ-026 S_COMMIT (one cycle, consumes no byte): write accumulator[7:0] to element[count].
REQ-027 In S_COMMIT, if count == m*n-1: next state S_DONE; otherwise count+1 and next state S_SKIP.
REQ-028 A byte whose rx_valid coincides with S_COMMIT is dropped; UART byte spacing guarantees this cannot occur.
REQ-029 S_DONE: done=1 and busy=0 for one cycle; next state S_IDLE.
REQ-030 S_ERR: error=1 and busy=0 for one cycle; next state S_IDLE.
REQ-031 mat_out holds its contents after done or error until the next accepted start; a partial matrix stays visible after an error.
REQ-032 rx_valid in S_IDLE is ignored; start while busy is ignored.
REQ-033 Row/column boundaries are not checked; the count alone decides completion, and bytes after the last separator belong to no read.
REQ-034 Latency: done asserts 2 cycles after the rx_valid of the final separator.

Reset
REQ-035 rst_n low asynchronously forces: state S_IDLE, mat_out=0, busy=0, done=0, error=0, err_code=0, count=0, accumulator=0.
REQ-036 Reset mid-read discards the partial matrix; no done or error pulse is produced.

Structure
REQ-037 State encodings, the ASCII constants (space, LF, CR, '0', '9') and the err_code values live in the shared project package; value_ascii_tx uses the same package.
REQ-038 One sub-module, ascii_digit_class: a combinational classifier, byte in -> is_digit, is_sep, digit value.
REQ-039 The element store is a flat register array addressed by count; no multiplier on the datapath except the m*n latched at start.

Verification
REQ-040 m=2, n=3, bytes "1 2 3\n4 5 6\n" -> elements 0..5 = 1,2,3,4,5,6; done pulses once; err_code=0.
REQ-041 m=1, n=1, bytes "256 " -> error pulse, err_code=3, element 0 = 0.
REQ-042 m=1, n=2, bytes "12 x" -> error, err_code=2, element 0 = 12.
REQ-043 m=6, n=1, start -> error on the cycle after start, err_code=1.
REQ-044 m=1, n=2, bytes "  007\r\n255 " -> elements 7, 255; done.
REQ-045 rst_n low after 3 of 4 elements, then a new 2x2 read "9 8 7 6 " -> mat_out = 9,8,7,6, other bits zero, one done pulse.

Source files
------------

// File: rtl/matrix_ascii_rx_pkg.sv
// Shared definitions for the ASCII matrix receiver and its companion
// transmitter: state encodings, ASCII constants, error codes and a small
// dimension-check helper.
package matrix_ascii_rx_pkg;

    // Receiver state encodings
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SKIP   = 3'd1;
    localparam logic [2:0] S_NUM    = 3'd2;
    localparam logic [2:0] S_COMMIT = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;
    localparam logic [2:0] S_ERR    = 3'd5;

    // ASCII characters the parser cares about
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_NINE  = 8'h39;

    // Error causes reported on err_code
    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_DIM  = 2'd1;
    localparam logic [1:0] ERR_CHAR = 2'd2;
    localparam logic [1:0] ERR_OVF  = 2'd3;

    // Largest value an element may take
    localparam logic [11:0] ACC_LIMIT = 12'd255;

    // A dimension is unusable when it is zero or larger than the store allows
    function automatic logic dim_invalid(input logic [3:0] dim, input logic [3:0] max_dim);
        return (dim == 4'd0) || (dim > max_dim);
    endfunction

endpackage

// File: rtl/ascii_digit_class.sv
// Combinational byte classifier: flags decimal digits and separators and
// returns the numeric value of a digit.
module ascii_digit_class
    import matrix_ascii_rx_pkg::*;
(
    input  logic [7:0] byte_in,
    output logic       is_digit,
    output logic       is_sep,
    output logic [3:0] digit_val
);

    // Classify the incoming byte; the low nibble of '0'..'9' is its value
    always_comb begin
        is_digit  = 1'b0;
        is_sep    = 1'b0;
        digit_val = 4'd0;
        if ((byte_in >= ASCII_ZERO) && (byte_in <= ASCII_NINE)) begin
            is_digit  = 1'b1;
            digit_val = byte_in[3:0];
        end else begin
            is_digit  = 1'b0;
            digit_val = 4'd0;
        end
        case (byte_in)
            ASCII_SPACE, ASCII_LF, ASCII_CR: is_sep = 1'b1;
            default:                         is_sep = 1'b0;
        endcase
    end

endmodule

// File: rtl/matrix_ascii_rx.sv
// Receives an m x n matrix of decimal numbers as ASCII text from a UART
// byte stream and stores it row-major in a flat element register array.
module matrix_ascii_rx
    import matrix_ascii_rx_pkg::*;
#(
    parameter int ELEM_WIDTH = 8,
    parameter int MAX_DIM    = 5
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  start,
    input  logic [3:0]                            m,
    input  logic [3:0]                            n,
    input  logic                                  rx_valid,
    input  logic [7:0]                            rx_data,
    output logic [MAX_DIM*MAX_DIM*ELEM_WIDTH-1:0] mat_out,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  error,
    output logic [1:0]                            err_code
);

    localparam int         NUM_ELEM  = MAX_DIM * MAX_DIM;
    localparam int         CNT_W     = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1;
    localparam logic [3:0] MAX_DIM_L = 4'(MAX_DIM);

    // Registered state
    logic [2:0]            state_r;
    logic [11:0]           acc_r;
    logic [CNT_W-1:0]      count_r;
    logic [7:0]            total_m1_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  error_r;
    logic [1:0]            err_code_r;
    logic [ELEM_WIDTH-1:0] elem_r [NUM_ELEM];

    // Combinational control
    logic [2:0]  state_nx_s;
    logic [11:0] acc_nx_s;
    logic [11:0] acc_step_s;
    logic        accept_s;
    logic        commit_s;
    logic        last_s;
    logic        dim_bad_s;
    logic        err_set_s;
    logic [1:0]  err_val_s;

    // Byte classification
    logic       is_digit_s;
    logic       is_sep_s;
    logic [3:0] digit_val_s;

    ascii_digit_class u_class (
        .byte_in   (rx_data),
        .is_digit  (is_digit_s),
        .is_sep    (is_sep_s),
        .digit_val (digit_val_s)
    );

    assign dim_bad_s  = dim_invalid(m, MAX_DIM_L) || dim_invalid(n, MAX_DIM_L);
    assign acc_step_s = (acc_r * 12'd10) + {8'd0, digit_val_s};
    assign last_s     = (8'(count_r) == total_m1_r);

    // Next-state and datapath control for the parser FSM
    always_comb begin
        state_nx_s = state_r;
        acc_nx_s   = acc_r;
        accept_s   = 1'b0;
        commit_s   = 1'b0;
        err_set_s  = 1'b0;
        err_val_s  = ERR_NONE;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    accept_s = 1'b1;
                    acc_nx_s = 12'd0;
                    if (dim_bad_s) begin
                        state_nx_s = S_ERR;
                        err_set_s  = 1'b1;
                        err_val_s  = ERR_DIM;
                    end else begin
                        state_nx_s = S_SKIP;
                    end
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_SKIP: begin
                if (rx_valid) begin
                    if (is_sep_s) begin
                        state_nx_s = S_SKIP;
                    end else if (is_digit_s) begin
                        acc_nx_s   = {8'd0, digit_val_s};
                        state_nx_s = S_NUM;
                    end else begin
                        state_nx_s = S_ERR;
                        err_set_s  = 1'b1;
                        err_val_s  = ERR_CHAR;
                    end
                end else begin
                    state_nx_s = S_SKIP;
                end
            end
            S_NUM: begin
                if (rx_valid) begin
                    if (is_digit_s) begin
                        if (acc_step_s > ACC_LIMIT) begin
                            state_nx_s = S_ERR;
                            err_set_s  = 1'b1;
                            err_val_s  = ERR_OVF;
                        end else begin
                            acc_nx_s   = acc_step_s;
                            state_nx_s = S_NUM;
                        end
                    end else if (is_sep_s) begin
                        state_nx_s = S_COMMIT;
                    end else begin
                        state_nx_s = S_ERR;
                        err_set_s  = 1'b1;
                        err_val_s  = ERR_CHAR;
                    end
                end else begin
                    state_nx_s = S_NUM;
                end
            end
            S_COMMIT: begin
                commit_s = 1'b1;
                if (last_s) begin
                    state_nx_s = S_DONE;
                end else begin
                    state_nx_s = S_SKIP;
                end
            end
            S_DONE:  state_nx_s = S_IDLE;
            S_ERR:   state_nx_s = S_IDLE;
            default: state_nx_s = S_IDLE;
        endcase
    end

    // FSM, accumulator, element counter and status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= S_IDLE;
            acc_r      <= 12'd0;
            count_r    <= '0;
            total_m1_r <= 8'd0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            error_r    <= 1'b0;
            err_code_r <= ERR_NONE;
        end else begin
            state_r <= state_nx_s;
            acc_r   <= acc_nx_s;
            done_r  <= (state_nx_s == S_DONE);
            error_r <= (state_nx_s == S_ERR);
            busy_r  <= (state_nx_s == S_SKIP) || (state_nx_s == S_NUM) ||
                       (state_nx_s == S_COMMIT);
            if (accept_s) begin
                count_r    <= '0;
                total_m1_r <= (8'(m) * 8'(n)) - 8'd1;
                err_code_r <= ERR_NONE;
            end else if (commit_s && !last_s) begin
                count_r <= count_r + CNT_W'(1);
            end else begin
                count_r <= count_r;
            end
            // A dimension error at start overrides the clear above
            if (err_set_s) begin
                err_code_r <= err_val_s;
            end
        end
    end

    // Element store: cleared on a new read, written one element per commit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ELEM; i++) begin
                elem_r[i] <= '0;
            end
        end else if (accept_s) begin
            for (int i = 0; i < NUM_ELEM; i++) begin
                elem_r[i] <= '0;
            end
        end else if (commit_s) begin
            elem_r[count_r] <= ELEM_WIDTH'(acc_r[7:0]);
        end
    end

    // Flatten the element store onto the row-major output bus
    always_comb begin
        mat_out = '0;
        for (int i = 0; i < NUM_ELEM; i++) begin
            mat_out[i*ELEM_WIDTH +: ELEM_WIDTH] = elem_r[i];
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign error    = error_r;
    assign err_code = err_code_r;

endmodule

// File: tb/tb_matrix_ascii_rx.sv
// Self-checking bench for matrix_ascii_rx: directed vectors plus randomized
// streams checked against a token-level parsing model.
module tb_matrix_ascii_rx;

    localparam int EW = 8;
    localparam int MD = 5;
    localparam int NE = MD * MD;
    localparam int MW = NE * EW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [3:0]    m = 4'd0;
    logic [3:0]    n = 4'd0;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_data = 8'd0;
    logic [MW-1:0] mat_out;
    logic          busy;
    logic          done;
    logic          error;
    logic [1:0]    err_code;

    matrix_ascii_rx #(.ELEM_WIDTH(EW), .MAX_DIM(MD)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .m        (m),
        .n        (n),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .mat_out  (mat_out),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .err_code (err_code)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Cycle counter and pulse monitor, sampled just after each rising edge
    int cyc = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int done_cyc = 0;
    int err_cyc = 0;
    always begin
        @(posedge clk);
        #1;
        cyc++;
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (error === 1'b1) begin
            err_cnt++;
            err_cyc = cyc;
        end
    end

    // Stimulus bytes and model results
    logic [7:0]    stim_q[$];
    logic [MW-1:0] exp_mat;
    logic [1:0]    exp_code;
    int            exp_outcome;  // 0 none, 1 done, 2 error
    int            exp_end;      // index of byte that finishes the read, -1 = at start

    task automatic load_str(input string s);
        stim_q.delete();
        for (int i = 0; i < s.len(); i++) stim_q.push_back(s[i]);
    endtask

    // Reference: tokenise the text into numbers and decide the outcome
    task automatic model_run(input int mm, input int nn);
        int total;
        int k;
        int val;
        bit in_num;
        int c;
        exp_mat = '0;
        exp_code = 2'd0;
        exp_outcome = 0;
        exp_end = -1;
        if (mm < 1 || mm > MD || nn < 1 || nn > MD) begin
            exp_outcome = 2;
            exp_code = 2'd1;
            return;
        end
        total = mm * nn;
        k = 0;
        val = 0;
        in_num = 0;
        foreach (stim_q[i]) begin
            c = int'(stim_q[i]);
            if (c >= 48 && c <= 57) begin
                val = in_num ? (val * 10 + c - 48) : (c - 48);
                in_num = 1;
                if (val > 255) begin
                    exp_outcome = 2; exp_code = 2'd3; exp_end = i;
                    return;
                end
            end else if (c == 32 || c == 10 || c == 13) begin
                if (in_num) begin
                    exp_mat[k*EW +: EW] = val[7:0];
                    k++;
                    in_num = 0;
                    if (k == total) begin
                        exp_outcome = 1; exp_end = i;
                        return;
                    end
                end
            end else begin
                exp_outcome = 2; exp_code = 2'd2; exp_end = i;
                return;
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, output int bc);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data = b;
        bc = cyc;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
    endtask

    task automatic do_start(input int mm, input int nn, output int sc);
        @(negedge clk);
        start = 1'b1;
        m = mm[3:0];
        n = nn[3:0];
        sc = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_read(input int mm, input int nn, input int poke_idx, input string tag);
        int d0;
        int e0;
        int ref_cyc;
        int bc;
        int waited;
        model_run(mm, nn);
        d0 = done_cnt;
        e0 = err_cnt;
        do_start(mm, nn, ref_cyc);
        if (exp_code != 2'd1) begin
            n_cmp++;
            if (busy !== 1'b1) begin
                n_bad++;
                $display("FAIL %s busy_after_start: got %b want 1", tag, busy);
            end
        end
        foreach (stim_q[i]) begin
            send_byte(stim_q[i], bc);
            if (i == exp_end) ref_cyc = bc;
            if (i == poke_idx) begin
                @(negedge clk);
                start = 1'b1; m = 4'd6; n = 4'd0;
                @(negedge clk);
                start = 1'b0;
            end
        end
        waited = 0;
        while (done_cnt == d0 && err_cnt == e0 && waited < 60) begin
            @(negedge clk);
            waited++;
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if ((done_cnt - d0) != ((exp_outcome == 1) ? 1 : 0)) begin
            n_bad++;
            $display("FAIL %s done_pulses: got %0d want %0d", tag, done_cnt - d0, (exp_outcome == 1) ? 1 : 0);
        end
        n_cmp++;
        if ((err_cnt - e0) != ((exp_outcome == 2) ? 1 : 0)) begin
            n_bad++;
            $display("FAIL %s error_pulses: got %0d want %0d", tag, err_cnt - e0, (exp_outcome == 2) ? 1 : 0);
        end
        n_cmp++;
        if (err_code !== exp_code) begin
            n_bad++;
            $display("FAIL %s err_code: got %0d want %0d", tag, err_code, exp_code);
        end
        n_cmp++;
        if (mat_out !== exp_mat) begin
            n_bad++;
            $display("FAIL %s mat_out: got %h want %h", tag, mat_out, exp_mat);
        end
        if (exp_outcome == 1 && done_cnt != d0) begin
            n_cmp++;
            if (done_cyc - ref_cyc != 2) begin
                n_bad++;
                $display("FAIL %s done_latency: got %0d want 2", tag, done_cyc - ref_cyc);
            end
        end
        if (exp_outcome == 2 && err_cnt != e0) begin
            n_cmp++;
            if (err_cyc - ref_cyc != 1) begin
                n_bad++;
                $display("FAIL %s error_latency: got %0d want 1", tag, err_cyc - ref_cyc);
            end
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s busy_after_end: got %b want 0", tag, busy);
        end
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if (mat_out !== '0 || busy !== 1'b0 || done !== 1'b0 || error !== 1'b0 || err_code !== 2'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got mat=%h busy=%b done=%b err=%b code=%0d want all 0",
                     mat_out, busy, done, error, err_code);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_spec_vectors();
        load_str("1 2 3\n4 5 6\n");  run_read(2, 3, -1, "vec_2x3");
        load_str("256 ");            run_read(1, 1, -1, "vec_overflow");
        load_str("12 x");            run_read(1, 2, -1, "vec_badchar");
        load_str("");                run_read(6, 1, -1, "vec_baddim");
        load_str("  007\r\n255 ");   run_read(1, 2, -1, "vec_leading_zero");
    endtask

    task automatic test_idle_ignore();
        int d0;
        int e0;
        int bc;
        d0 = done_cnt;
        e0 = err_cnt;
        load_str("12 34\nz9 ");
        foreach (stim_q[i]) send_byte(stim_q[i], bc);
        n_cmp++;
        if (mat_out !== exp_mat || done_cnt != d0 || err_cnt != e0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_ignore: got mat=%h pulses=%0d/%0d want mat=%h pulses=0/0",
                     mat_out, done_cnt - d0, err_cnt - e0, exp_mat);
        end
    endtask

    task automatic test_start_while_busy();
        load_str("11 22 33 44 ");
        run_read(2, 2, 1, "start_busy");
    endtask

    task automatic test_reset_midread();
        int sc;
        int bc;
        int d0;
        int e0;
        logic [MW-1:0] part;
        load_str("1 2 3 ");
        do_start(2, 2, sc);
        foreach (stim_q[i]) send_byte(stim_q[i], bc);
        part = '0;
        part[7:0] = 8'd1; part[15:8] = 8'd2; part[23:16] = 8'd3;
        n_cmp++;
        if (mat_out !== part || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL partial_before_reset: got mat=%h busy=%b want mat=%h busy=1", mat_out, busy, part);
        end
        d0 = done_cnt;
        e0 = err_cnt;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (mat_out !== '0 || busy !== 1'b0 || err_code !== 2'd0) begin
            n_bad++;
            $display("FAIL midread_reset: got mat=%h busy=%b code=%0d want 0", mat_out, busy, err_code);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        n_cmp++;
        if (done_cnt != d0 || err_cnt != e0) begin
            n_bad++;
            $display("FAIL reset_no_pulse: got done=%0d err=%0d want 0 0", done_cnt - d0, err_cnt - e0);
        end
        load_str("9 8 7 6 ");
        run_read(2, 2, -1, "after_reset_2x2");
    endtask

    task automatic test_random();
        int mm;
        int nn;
        int mode;
        int bad_at;
        int val;
        string s;
        logic [7:0] illegal [5];
        illegal[0] = 8'h2C; illegal[1] = 8'h78; illegal[2] = 8'h09;
        illegal[3] = 8'h41; illegal[4] = 8'hFF;
        for (int r = 0; r < 30; r++) begin
            if ($urandom_range(0, 7) == 0) begin
                mm = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(6, 15);
                nn = $urandom_range(0, 15);
            end else begin
                mm = $urandom_range(1, 5);
                nn = $urandom_range(1, 5);
            end
            mode = $urandom_range(0, 5);
            bad_at = $urandom_range(0, mm * nn - 1);
            stim_q.delete();
            repeat ($urandom_range(0, 2)) stim_q.push_back(8'h20);
            for (int e = 0; e < mm * nn && e < NE; e++) begin
                val = (mode == 0 && e == bad_at) ? $urandom_range(256, 999) : $urandom_range(0, 255);
                repeat ($urandom_range(0, 2)) stim_q.push_back(8'h30);
                s = $sformatf("%0d", val);
                for (int i = 0; i < s.len(); i++) stim_q.push_back(s[i]);
                if (mode == 1 && e == bad_at) stim_q.push_back(illegal[$urandom_range(0, 4)]);
                case ($urandom_range(0, 2))
                    0: stim_q.push_back(8'h20);
                    1: stim_q.push_back(8'h0A);
                    default: begin stim_q.push_back(8'h0D); stim_q.push_back(8'h0A); end
                endcase
            end
            if ($urandom_range(0, 1) == 1) begin
                stim_q.push_back(8'h37);
                stim_q.push_back(8'h20);
            end
            run_read(mm, nn, -1, $sformatf("rand%0d_%0dx%0d", r, mm, nn));
        end
    endtask

    initial begin
        test_reset();
        test_spec_vectors();
        test_idle_ignore();
        test_start_while_busy();
        test_reset_midread();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
